ldm_seq: RTL and testbench

- Parametrised block-transfer (LDM/STM) sequencer for the execute stage.
- Latches one multiple-transfer instruction, counts its registers and computes the start address for all four addressing modes (IA/IB/DA/DB).
- Issues one memory beat per register over a req/ack handshake, then produces base writeback, pipeline flush and SPSR-restore controls.
- Stalls the upstream pipeline while busy.

---
 rtl/ldm_pkg.sv | 26 ++
 rtl/lsb_onehot_enc.sv | 23 ++
 rtl/ldm_seq.sv | 136 +++++++++++++
 tb/tb_ldm_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ldm_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package ldm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Addressing modes keyed by {p, u}
  localparam logic [1:0] DA = 2'b00;
  localparam logic [1:0] IA = 2'b01;
  localparam logic [1:0] DB = 2'b10;
  localparam logic [1:0] IB = 2'b11;

  localparam int WORD    = 4;
  localparam int POP_MAX = 64;

  function automatic logic [7:0] popcount(input logic [POP_MAX-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/lsb_onehot_enc.sv
// Lowest-set-bit encoder: one-hot mask, binary index, and "exactly one bit set" flag.
module lsb_onehot_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic [W-1:0] code,
  output logic         single
);

  assign onehot = vec & (~vec + N'(1));
  assign single = (vec != '0) && ((vec & (vec - N'(1))) == '0);

  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) code = W'(i);
    end
  end

endmodule

// File: rtl/ldm_seq.sv
// Block-transfer (LDM/STM) sequencer: one beat per listed register, then writeback/flush/SPSR pulses.
import ldm_pkg::*;

module ldm_seq #(
  parameter int NREGS  = 16,
  parameter int ADDR_W = 32,
  parameter int PC_IDX = 15,
  parameter int RC_W   = $clog2(NREGS),
  parameter int CNT_W  = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              i_vld,
  input  logic              i_p,
  input  logic              i_u,
  input  logic              i_s,
  input  logic              i_l,
  input  logic              i_w,
  input  logic [RC_W-1:0]   i_rn,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [NREGS-1:0]  i_reglist,
  input  logic              i_mem_ack,
  output logic              o_busy,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [RC_W-1:0]   o_reg_code,
  output logic              o_last,
  output logic              o_user_bank,
  output logic              o_wb_vld,
  output logic [RC_W-1:0]   o_wb_rn,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic              o_flushreq,
  output logic              o_spsr_res
);

  localparam logic [ADDR_W-1:0] WSTEP = ADDR_W'(WORD);

  state_t              state_q, state_d;
  logic [NREGS-1:0]    list_q;
  logic [ADDR_W-1:0]   addr_q, wb_q;
  logic [RC_W-1:0]     rn_q;
  logic                l_q, s_q, w_q, base_in_q, pc_in_q;

  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   span, start_addr, wb_next;
  logic [NREGS-1:0]    onehot;
  logic [RC_W-1:0]     code;
  logic                single, start, xfer, done, beat_ack;

  lsb_onehot_enc #(.N(NREGS), .W(RC_W)) u_enc (
    .vec    (list_q),
    .onehot (onehot),
    .code   (code),
    .single (single)
  );

  assign cnt      = CNT_W'(popcount(POP_MAX'(i_reglist)));
  assign span     = ADDR_W'(cnt) * WSTEP;
  assign wb_next  = i_u ? i_base + span : i_base - span;
  assign xfer     = (state_q == XFER);
  assign done     = (state_q == DONE);
  assign start    = en && i_vld && (i_reglist != '0) && (state_q == IDLE);
  assign beat_ack = en && i_mem_ack && xfer;

  always_comb begin
    case ({i_p, i_u})
      IA:      start_addr = i_base;
      IB:      start_addr = i_base + WSTEP;
      DA:      start_addr = i_base - span + WSTEP;
      default: start_addr = i_base - span;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (start) state_d = XFER;
        XFER:    if (i_mem_ack && single) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Base-in-list and PC-in-list are captured up front: the live list is empty by DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      list_q    <= '0;
      addr_q    <= '0;
      wb_q      <= '0;
      rn_q      <= '0;
      l_q       <= 1'b0;
      s_q       <= 1'b0;
      w_q       <= 1'b0;
      base_in_q <= 1'b0;
      pc_in_q   <= 1'b0;
    end else if (start) begin
      list_q    <= i_reglist;
      addr_q    <= start_addr;
      wb_q      <= wb_next;
      rn_q      <= i_rn;
      l_q       <= i_l;
      s_q       <= i_s;
      w_q       <= i_w;
      base_in_q <= i_reglist[i_rn];
      pc_in_q   <= i_reglist[PC_IDX];
    end else if (beat_ack) begin
      list_q <= list_q & ~onehot;
      addr_q <= addr_q + WSTEP;
    end
  end

  always_comb begin
    o_busy      = (state_q != IDLE);
    o_mem_req   = en && xfer;
    o_mem_we    = xfer && !l_q;
    o_mem_addr  = xfer ? addr_q : '0;
    o_reg_code  = xfer ? code : '0;
    o_last      = xfer && single;
    o_user_bank = xfer && s_q && !(l_q && pc_in_q);
    o_wb_vld    = en && done && w_q && !(l_q && base_in_q);
    o_wb_rn     = done ? rn_q : '0;
    o_wb_addr   = done ? wb_q : '0;
    o_flushreq  = en && done && l_q && pc_in_q;
    o_spsr_res  = en && done && l_q && s_q && pc_in_q;
  end

endmodule

// File: tb/tb_ldm_seq.sv
// Scoreboard bench for ldm_seq: directed instructions push expected beats/DONE records, a monitor compares.
module tb_ldm_seq;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  code;
    logic        last;
    logic        ub;
  } beat_t;

  typedef struct packed {
    logic        wb;
    logic [3:0]  rn;
    logic [31:0] addr;
    logic        flush;
    logic        spsr;
  } done_t;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic        i_vld = 1'b0, i_p = 1'b0, i_u = 1'b0, i_s = 1'b0, i_l = 1'b0, i_w = 1'b0;
  logic [3:0]  i_rn = '0;
  logic [31:0] i_base = '0;
  logic [15:0] i_reglist = '0;
  logic        i_mem_ack = 1'b1;
  logic        o_busy, o_mem_req, o_mem_we, o_last, o_user_bank, o_wb_vld, o_flushreq, o_spsr_res;
  logic [31:0] o_mem_addr, o_wb_addr;
  logic [3:0]  o_reg_code, o_wb_rn;

  beat_t beat_q[$];
  done_t done_q[$];
  beat_t mb, me;
  done_t md, mde;
  int    checks = 0, errors = 0;

  ldm_seq dut (
    .clk(clk), .rst(rst), .en(en), .i_vld(i_vld), .i_p(i_p), .i_u(i_u), .i_s(i_s),
    .i_l(i_l), .i_w(i_w), .i_rn(i_rn), .i_base(i_base), .i_reglist(i_reglist),
    .i_mem_ack(i_mem_ack), .o_busy(o_busy), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_reg_code(o_reg_code), .o_last(o_last),
    .o_user_bank(o_user_bank), .o_wb_vld(o_wb_vld), .o_wb_rn(o_wb_rn),
    .o_wb_addr(o_wb_addr), .o_flushreq(o_flushreq), .o_spsr_res(o_spsr_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic beat(input logic we, input logic [31:0] a, input logic [3:0] c,
                      input logic last, input logic ub);
    beat_q.push_back({we, a, c, last, ub});
  endtask

  task automatic fin(input logic wb, input logic [3:0] rn, input logic [31:0] a,
                     input logic fl, input logic sp);
    done_q.push_back({wb, rn, a, fl, sp});
  endtask

  task automatic issue(input logic p, input logic u, input logic s, input logic l, input logic w,
                       input logic [3:0] rn, input logic [31:0] base, input logic [15:0] list);
    @(posedge clk); #1;
    i_vld = 1'b1; i_p = p; i_u = u; i_s = s; i_l = l; i_w = w;
    i_rn = rn; i_base = base; i_reglist = list;
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  // Monitor: a beat completes on req&ack; DONE is the only busy cycle without req while enabled.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_mem_req && i_mem_ack) begin
        mb = {o_mem_we, o_mem_addr, o_reg_code, o_last, o_user_bank};
        if (beat_q.size() == 0) chk("unexpected_beat", 64'(mb), 0);
        else begin
          me = beat_q.pop_front();
          chk("beat", 64'(mb), 64'(me));
        end
      end
      if (en && o_busy && !o_mem_req) begin
        md = {o_wb_vld, o_wb_rn, o_wb_addr, o_flushreq, o_spsr_res};
        if (done_q.size() == 0) chk("unexpected_done", 64'(md), 0);
        else begin
          mde = done_q.pop_front();
          if (!mde.wb) begin
            md.rn = '0; md.addr = '0; mde.rn = '0; mde.addr = '0;
          end
          chk("done", 64'(md), 64'(mde));
        end
      end else if (o_wb_vld || o_flushreq || o_spsr_res) begin
        chk("stray_pulse", {o_wb_vld, o_flushreq, o_spsr_res}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", {o_busy, o_mem_req, o_mem_we, o_mem_addr, o_reg_code, o_last, o_user_bank}, 0);
    chk("reset_b", {o_wb_vld, o_wb_rn, o_wb_addr, o_flushreq, o_spsr_res}, 0);
    rst = 1'b0;

    // STMIA base 0x1000 {r0,r1,r3}, W=1
    beat(1, 32'h1000, 0, 0, 0); beat(1, 32'h1004, 1, 0, 0); beat(1, 32'h1008, 3, 1, 0);
    fin(1, 4, 32'h100C, 0, 0);
    issue(0, 1, 0, 0, 1, 4, 32'h1000, 16'h000B);
    wait_idle(n);
    chk("total_cycles", n + 1, 5);

    // LDMDB base 0x2000 {r0,r1,pc}, W=1, S=1, Rn=13
    beat(0, 32'h1FF4, 0, 0, 0); beat(0, 32'h1FF8, 1, 0, 0); beat(0, 32'h1FFC, 15, 1, 0);
    fin(1, 13, 32'h1FF4, 1, 1);
    issue(1, 0, 1, 1, 1, 13, 32'h2000, 16'h8003);
    wait_idle(n);

    // STMDA base 0x3000 {r1,r2}, S=1: user bank on a store
    beat(1, 32'h2FFC, 1, 0, 1); beat(1, 32'h3000, 2, 1, 1);
    fin(0, 0, 0, 0, 0);
    issue(0, 0, 1, 0, 0, 0, 32'h3000, 16'h0006);
    wait_idle(n);

    // LDMIA Rn=2 {r2}, W=1: base loaded, writeback suppressed
    beat(0, 32'h5000, 2, 1, 0);
    fin(0, 0, 0, 0, 0);
    issue(0, 1, 0, 1, 1, 2, 32'h5000, 16'h0004);
    wait_idle(n);
    // STMIA same list: writeback stands
    beat(1, 32'h5000, 2, 1, 0);
    fin(1, 2, 32'h5004, 0, 0);
    issue(0, 1, 0, 0, 1, 2, 32'h5000, 16'h0004);
    wait_idle(n);

    // STMIA base 0x3000 {r4..r7}: ack withheld 3 cycles on beat 2, then en=0 for 2 cycles
    beat(1, 32'h3000, 4, 0, 0); beat(1, 32'h3004, 5, 0, 0);
    beat(1, 32'h3008, 6, 0, 0); beat(1, 32'h300C, 7, 1, 0);
    fin(0, 0, 0, 0, 0);
    issue(0, 1, 0, 0, 0, 0, 32'h3000, 16'h00F0);
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ack_hold", {o_mem_req, o_mem_addr, o_reg_code, o_last}, {1'b1, 32'h3004, 4'd5, 1'b0});
      @(posedge clk); #1;
    end
    en = 1'b0; i_mem_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("en0_hold", {o_mem_req, o_mem_addr, o_reg_code}, {1'b0, 32'h3004, 4'd5});
      @(posedge clk); #1;
    end
    en = 1'b1;
    wait_idle(n);

    // Empty list is ignored
    issue(0, 1, 0, 0, 1, 0, 32'h6000, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      chk("empty_list", {o_busy, o_mem_req}, 0);
    end

    // IB wrap-around past 2^32
    beat(1, 32'h0000_0000, 0, 1, 0);
    fin(1, 1, 32'h0000_0000, 0, 0);
    issue(1, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 16'h0001);
    wait_idle(n);

    // Reset during beat 2 of 4: no DONE pulses must follow
    beat(0, 32'h4000, 0, 0, 0);
    issue(0, 1, 0, 1, 1, 9, 32'h4000, 16'h000F);
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_a", {o_busy, o_mem_req, o_mem_we, o_mem_addr, o_reg_code, o_last, o_user_bank}, 0);
    chk("rst_mid_b", {o_wb_vld, o_wb_rn, o_wb_addr, o_flushreq, o_spsr_res}, 0);
    @(posedge clk); #1;
    rst = 1'b0; i_mem_ack = 1'b1;

    // Normal operation afterwards
    beat(1, 32'h1000, 0, 0, 0); beat(1, 32'h1004, 1, 0, 0); beat(1, 32'h1008, 3, 1, 0);
    fin(1, 4, 32'h100C, 0, 0);
    issue(0, 1, 0, 0, 1, 4, 32'h1000, 16'h000B);
    wait_idle(n);
    chk("total_cycles_after_rst", n + 1, 5);

    repeat (3) @(posedge clk);
    chk("beats_left", beat_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
